// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: accepts decoded instruction fields during a load
// session and writes the 32-bit machine words to consecutive instruction-memory addresses.
module legv8_instr_encoder (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        load_start,
    input  logic [63:0] base_addr,
    input  logic        load_end,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rn,
    input  logic [4:0]  in_rm,
    input  logic [31:0] in_imm,
    input  logic [1:0]  in_hw,
    output logic        im_wr_en,
    output logic [63:0] im_addr,
    output logic [31:0] im_data,
    input  logic        im_ready,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [63:0] addr_r;
    logic [31:0] data_r;
    logic        wr_en_r;
    logic        done_r;
    logic        err_r;
    logic [7:0]  err_count_r;
    logic        acc_s;
    logic [32:0] enc_s;
    logic        enc_ok_s;
    logic [31:0] enc_word_s;

    // Returns {valid, word}; valid is low for unknown ops or immediates that do not fit.
    function automatic logic [32:0] encode_instr(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rn,
        input logic [4:0]  rm,
        input logic [31:0] imm,
        input logic [1:0]  hw
    );
        logic        ok;
        logic [31:0] w;
        ok = 1'b1;
        w  = 32'd0;
        case (op)
            4'd0: w = {11'b10001010000, rm, 6'd0, rn, rd};
            4'd1: w = {11'b10101010000, rm, 6'd0, rn, rd};
            4'd2: w = {11'b10001011000, rm, 6'd0, rn, rd};
            4'd3: w = {11'b11001011000, rm, 6'd0, rn, rd};
            4'd4: begin
                ok = (imm[31:12] == 20'd0);
                w  = {10'b1001000100, imm[11:0], rn, rd};
            end
            4'd5: begin
                ok = (imm[31:12] == 20'd0);
                w  = {10'b1101000100, imm[11:0], rn, rd};
            end
            4'd6: begin
                ok = (imm[31:16] == 16'd0);
                w  = {9'b110100101, hw, imm[15:0], rd};
            end
            // Signed ranges: every bit above the field's sign bit must equal the sign.
            4'd7: begin
                ok = (imm[31:25] == {7{imm[31]}});
                w  = {6'b000101, imm[25:0]};
            end
            4'd8: begin
                ok = (imm[31:18] == {14{imm[31]}});
                w  = {8'b10110100, imm[18:0], rd};
            end
            4'd9: begin
                ok = (imm[31:8] == {24{imm[31]}});
                w  = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
            end
            4'd10: begin
                ok = (imm[31:8] == {24{imm[31]}});
                w  = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
            end
            default: begin
                ok = 1'b0;
                w  = 32'd0;
            end
        endcase
        return {ok, w};
    endfunction

    // Handshake and encoder outputs for the instruction presented this cycle.
    always_comb begin
        in_ready   = (state_r == LOAD) && (!wr_en_r || im_ready);
        acc_s      = in_valid && in_ready;
        enc_s      = encode_instr(in_op, in_rd, in_rn, in_rm, in_imm, in_hw);
        enc_ok_s   = enc_s[32];
        enc_word_s = enc_s[31:0];
    end

    // Session sequencing; DRAIN waits for the output register to empty.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_start) state_s = LOAD;
                else            state_s = IDLE;
            end
            LOAD: begin
                if (load_end) state_s = DRAIN;
                else          state_s = LOAD;
            end
            DRAIN: begin
                if (!wr_en_r) state_s = IDLE;
                else          state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) state_r <= IDLE;
        else         state_r <= state_s;
    end

    // Output register, address counter and status pulses.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            addr_r      <= 64'd0;
            data_r      <= 32'd0;
            wr_en_r     <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            if (state_r == IDLE && load_start) addr_r <= base_addr;
            else if (wr_en_r && im_ready)      addr_r <= addr_r + 64'd4;
            else                               addr_r <= addr_r;

            if (acc_s && enc_ok_s) begin
                wr_en_r <= 1'b1;
                data_r  <= enc_word_s;
            end else if (im_ready) begin
                wr_en_r <= 1'b0;
            end else begin
                wr_en_r <= wr_en_r;
            end

            err_r <= acc_s && !enc_ok_s;
            if (acc_s && !enc_ok_s && err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
            else                                            err_count_r <= err_count_r;

            done_r <= (state_r == DRAIN) && !wr_en_r;
        end
    end

    assign im_wr_en  = wr_en_r;
    assign im_addr   = addr_r;
    assign im_data   = data_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed testbench for legv8_instr_encoder with hand-computed machine words.
module tb_legv8_instr_encoder;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        load_start;
    logic [63:0] base_addr;
    logic        load_end;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rn;
    logic [4:0]  in_rm;
    logic [31:0] in_imm;
    logic [1:0]  in_hw;
    logic        im_wr_en;
    logic [63:0] im_addr;
    logic [31:0] im_data;
    logic        im_ready;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [63:0] wa_q[$];
    logic [31:0] wd_q[$];

    legv8_instr_encoder dut (
        .CLK(CLK), .resetl(resetl), .load_start(load_start), .base_addr(base_addr),
        .load_end(load_end), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .in_hw(in_hw),
        .im_wr_en(im_wr_en), .im_addr(im_addr), .im_data(im_data), .im_ready(im_ready),
        .done(done), .err(err), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    // Record every completed memory write.
    always @(posedge CLK) begin
        if (resetl === 1'b1 && im_wr_en === 1'b1 && im_ready === 1'b1) begin
            wa_q.push_back(im_addr);
            wd_q.push_back(im_data);
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [31:0] imm, input logic [1:0] hw,
                        output logic got_err);
        int n;
        in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_hw = hw;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL send_ready_timeout in_ready=%b required=1", in_ready);
        end
        @(negedge CLK);
        in_valid = 1'b0;
        got_err = err;
    endtask

    task automatic start_session(input logic [63:0] b);
        load_start = 1'b1;
        base_addr  = b;
        @(negedge CLK);
        load_start = 1'b0;
    endtask

    task automatic end_session();
        int n;
        load_end = 1'b1;
        @(negedge CLK);
        load_end = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL done_timeout done=%b required=1", done);
        end
        @(negedge CLK);
        total++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle done=%b in_ready=%b required=0/0", done, in_ready);
        end
    endtask

    task automatic test_reset();
        total++;
        if (im_wr_en !== 1'b0 || im_addr !== 64'd0 || im_data !== 32'd0 || in_ready !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_state wr=%b addr=%h data=%h rdy=%b done=%b err=%b cnt=%0d required all zero",
                     im_wr_en, im_addr, im_data, in_ready, done, err, err_count);
        end
    endtask

    task automatic test_addreg();
        logic e;
        int q0;
        q0 = wd_q.size();
        im_ready = 1'b1;
        start_session(64'h100);
        send(4'd2, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0, e);
        total++;
        if (im_wr_en !== 1'b1 || im_addr !== 64'h100 || im_data !== 32'h8B030041 || e !== 1'b0) begin
            bad++;
            $display("FAIL addreg wr=%b addr=%h data=%h err=%b required 1/100/8b030041/0",
                     im_wr_en, im_addr, im_data, e);
        end
        end_session();
        total++;
        if (wd_q.size() != q0 + 1 || wa_q[q0] !== 64'h100 || wd_q[q0] !== 32'h8B030041) begin
            bad++;
            $display("FAIL addreg_write n=%0d required=%0d", wd_q.size(), q0 + 1);
        end
    endtask

    task automatic test_reject();
        logic e;
        int q0;
        q0 = wd_q.size();
        im_ready = 1'b1;
        start_session(64'h200);
        send(4'd4, 5'd1, 5'd1, 5'd0, 32'd4096, 2'd0, e);
        total++;
        if (e !== 1'b1 || im_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL reject_addimm err=%b wr=%b required 1/0", e, im_wr_en);
        end
        send(4'd12, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0, e);
        exp_cnt = exp_cnt + 2;
        total++;
        if (e !== 1'b1 || im_wr_en !== 1'b0 || err_count !== exp_cnt[7:0]) begin
            bad++;
            $display("FAIL reject_op12 err=%b wr=%b cnt=%0d required 1/0/%0d", e, im_wr_en, err_count, exp_cnt);
        end
        @(negedge CLK);
        total++;
        if (err !== 1'b0 || im_addr !== 64'h200 || wd_q.size() != q0) begin
            bad++;
            $display("FAIL reject_no_side_effect err=%b addr=%h writes=%0d required 0/200/%0d",
                     err, im_addr, wd_q.size(), q0);
        end
        send(4'd1, 5'd31, 5'd0, 5'd31, 32'd0, 2'd0, e);
        total++;
        if (im_addr !== 64'h200 || im_data !== 32'hAA1F001F) begin
            bad++;
            $display("FAIL reject_then_orr addr=%h data=%h required 200/aa1f001f", im_addr, im_data);
        end
        end_session();
    endtask

    task automatic test_boundaries();
        logic [3:0]  ops [9] = '{4'd5, 4'd4, 4'd8, 4'd8, 4'd10, 4'd9, 4'd6, 4'd7, 4'd0};
        logic [4:0]  rds [9] = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd1, 5'd1, 5'd0, 5'd0, 5'd5};
        logic [4:0]  rns [9] = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd6};
        logic [4:0]  rms [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7};
        logic [31:0] imms[9] = '{32'd4095, 32'hFFFFFFFF, 32'hFFFC0000, 32'h00040000, 32'd255,
                                 32'd256, 32'h00010000, 32'h02000000, 32'd0};
        logic        oks [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp_w[4] = '{32'hD13FFFE0, 32'hB4800007, 32'hF80FF041, 32'h8A0700C5};
        logic e;
        int q0;
        q0 = wd_q.size();
        im_ready = 1'b1;
        start_session(64'h1000);
        for (int i = 0; i < 9; i++) begin
            send(ops[i], rds[i], rns[i], rms[i], imms[i], 2'd0, e);
            if (!oks[i]) exp_cnt++;
            total++;
            if (e !== !oks[i]) begin
                bad++;
                $display("FAIL boundary_err[%0d] err=%b required=%b", i, e, !oks[i]);
            end
        end
        end_session();
        total++;
        if (err_count !== exp_cnt[7:0] || wd_q.size() != q0 + 4) begin
            bad++;
            $display("FAIL boundary_counts cnt=%0d writes=%0d required %0d/%0d",
                     err_count, wd_q.size() - q0, exp_cnt, 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (wd_q[q0 + i] !== exp_w[i] || wa_q[q0 + i] !== 64'h1000 + 64'(4 * i)) begin
                    bad++;
                    $display("FAIL boundary_word[%0d] addr=%h data=%h required %h/%h", i,
                             wa_q[q0 + i], wd_q[q0 + i], 64'h1000 + 64'(4 * i), exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_movz_b();
        logic e;
        int q0;
        q0 = wd_q.size();
        im_ready = 1'b1;
        start_session(64'hFFFF_FFFF_FFFF_FFFC);
        send(4'd6, 5'd9, 5'd0, 5'd0, 32'h0000BEEF, 2'd2, e);
        send(4'd7, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 2'd0, e);
        total++;
        if (im_addr !== 64'd0 || im_data !== 32'h17FFFFFF) begin
            bad++;
            $display("FAIL b_wrap addr=%h data=%h required 0/17ffffff", im_addr, im_data);
        end
        end_session();
        total++;
        if (wd_q.size() != q0 + 2 || wa_q[q0] !== 64'hFFFF_FFFF_FFFF_FFFC || wd_q[q0] !== 32'hD2D7DDE9 ||
            wa_q[q0 + 1] !== 64'd0 || wd_q[q0 + 1] !== 32'h17FFFFFF) begin
            bad++;
            $display("FAIL movz_b_writes n=%0d required=%0d", wd_q.size() - q0, 2);
        end
    endtask

    task automatic test_stall();
        logic e;
        int q0;
        q0 = wd_q.size();
        im_ready = 1'b1;
        start_session(64'h300);
        im_ready = 1'b0;
        send(4'd4, 5'd1, 5'd1, 5'd0, 32'd1, 2'd0, e);
        in_op = 4'd1; in_rd = 5'd31; in_rn = 5'd0; in_rm = 5'd31; in_imm = 32'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (in_ready !== 1'b0 || im_wr_en !== 1'b1 || im_data !== 32'h91000421 || im_addr !== 64'h300) begin
                bad++;
                $display("FAIL stall[%0d] rdy=%b wr=%b data=%h addr=%h required 0/1/91000421/300",
                         i, in_ready, im_wr_en, im_data, im_addr);
            end
            @(negedge CLK);
        end
        im_ready = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        total++;
        if (wd_q.size() != q0 + 1 || im_addr !== 64'h304 || im_data !== 32'hAA1F001F) begin
            bad++;
            $display("FAIL stall_release writes=%0d addr=%h data=%h required %0d/304/aa1f001f",
                     wd_q.size() - q0, im_addr, im_data, 1);
        end
        end_session();
        total++;
        if (wd_q.size() != q0 + 2 || wd_q[q0] !== 32'h91000421 || wa_q[q0 + 1] !== 64'h304) begin
            bad++;
            $display("FAIL stall_writes n=%0d required=%0d", wd_q.size() - q0, 2);
        end
    endtask

    task automatic test_load_end_coincident();
        int q0;
        q0 = wd_q.size();
        im_ready = 1'b1;
        start_session(64'h400);
        in_op = 4'd9; in_rd = 5'd4; in_rn = 5'd5; in_rm = 5'd0; in_imm = 32'hFFFFFFF8;
        in_valid = 1'b1;
        load_end = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        load_end = 1'b0;
        total++;
        if (im_wr_en !== 1'b1 || im_data !== 32'hF85F80A4 || im_addr !== 64'h400) begin
            bad++;
            $display("FAIL ldur_coincident wr=%b data=%h addr=%h required 1/f85f80a4/400",
                     im_wr_en, im_data, im_addr);
        end
        load_end = 1'b0;
        for (int n = 0; n < 20 && done !== 1'b1; n++) @(negedge CLK);
        total++;
        if (done !== 1'b1 || wd_q.size() != q0 + 1) begin
            bad++;
            $display("FAIL ldur_done done=%b writes=%0d required 1/%0d", done, wd_q.size() - q0, 1);
        end
        @(negedge CLK);
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ldur_idle rdy=%b done=%b required 0/0", in_ready, done);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midwrite();
        logic e;
        int q0;
        im_ready = 1'b1;
        start_session(64'h500);
        im_ready = 1'b0;
        send(4'd13, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0, e);
        send(4'd2, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0, e);
        q0 = wd_q.size();
        total++;
        if (im_wr_en !== 1'b1 || err_count === 8'd0) begin
            bad++;
            $display("FAIL midwrite_pre wr=%b cnt=%0d required 1/nonzero", im_wr_en, err_count);
        end
        #2 resetl = 1'b0;
        #1;
        total++;
        if (im_wr_en !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b0 || im_addr !== 64'd0 || im_data !== 32'd0) begin
            bad++;
            $display("FAIL async_reset wr=%b cnt=%0d rdy=%b addr=%h data=%h required all zero",
                     im_wr_en, err_count, in_ready, im_addr, im_data);
        end
        exp_cnt = 0;
        @(negedge CLK);
        resetl = 1'b1;
        im_ready = 1'b1;
        @(negedge CLK);
        total++;
        if (in_ready !== 1'b0 || im_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle rdy=%b wr=%b required 0/0", in_ready, im_wr_en);
        end
        start_session(64'h600);
        total++;
        if (in_ready !== 1'b1 || im_addr !== 64'h600) begin
            bad++;
            $display("FAIL post_reset_load rdy=%b addr=%h required 1/600", in_ready, im_addr);
        end
        end_session();
        total++;
        if (wd_q.size() != q0) begin
            bad++;
            $display("FAIL discarded_write writes=%0d required=%0d", wd_q.size() - q0, 0);
        end
    endtask

    initial begin
        resetl = 1'b0; load_start = 1'b0; base_addr = 64'd0; load_end = 1'b0;
        in_valid = 1'b0; in_op = 4'd0; in_rd = 5'd0; in_rn = 5'd0; in_rm = 5'd0;
        in_imm = 32'd0; in_hw = 2'd0; im_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        test_reset();
        resetl = 1'b1;
        @(negedge CLK);
        test_addreg();
        test_reject();
        test_boundaries();
        test_movz_b();
        test_stall();
        test_load_end_coincident();
        test_reset_midwrite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
